// File: rtl/axil_bridge_pkg.sv
// axil_bridge_pkg: shared types and the address decode helper for the AXI4-Lite to native bridge.
package axil_bridge_pkg;
   typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} resp_t;
   typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;
   typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;
   typedef struct packed {
      logic        err;
      logic [63:0] word;
   } dec_t;
   // Byte address to native word address; misaligned or out-of-window addresses flag err.
   function automatic dec_t addr_decode(logic [63:0] addr, int nat_w);
      dec_t d;
      d.err  = (addr[2:0] != 3'd0) || ((addr >> (nat_w + 3)) != 64'd0);
      d.word = (addr >> 3) & ((64'd1 << nat_w) - 64'd1);
      return d;
   endfunction
endpackage

// File: rtl/axil_native_bridge.sv
// axil_native_bridge: AXI4-Lite subordinate driving a single-beat native register port.
// Ports: clk, rst (async, active-high); AXI AW/W/B/AR/R channels (s_*);
// native initiator nat_en/nat_we/nat_addr/nat_wdata and nat_rdata returned RD_LATENCY cycles after issue.
module axil_native_bridge
   import axil_bridge_pkg::*;
#(
   parameter int AXI_ADDR_W = 32,
   parameter int DATA_W     = 64,
   parameter int NAT_ADDR_W = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AXI_ADDR_W-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [AXI_ADDR_W-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic                  nat_en,
   output logic                  nat_we,
   output logic [NAT_ADDR_W-1:0] nat_addr,
   output logic [DATA_W-1:0]     nat_wdata,
   input  logic [DATA_W-1:0]     nat_rdata
);
   state_t                state_q, state_d;
   grant_t                last_grant_q, last_grant_d;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [AXI_ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0]     w_data_q, w_data_d;
   logic [DATA_W/8-1:0]   w_strb_q, w_strb_d;
   logic                  nat_en_q, nat_en_d, nat_we_q, nat_we_d;
   logic [NAT_ADDR_W-1:0] nat_addr_q, nat_addr_d;
   logic [DATA_W-1:0]     nat_wdata_q, nat_wdata_d;
   resp_t                 bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  idle, wr_rdy, rd_gnt, wr_gnt, wr_ok;
   dec_t                  wr_dec, rd_dec;

   // Readies are held low while rst is asserted, not just after it releases.
   assign idle      = (state_q == IDLE) && !rst;
   assign wr_rdy    = aw_held_q && w_held_q;
   // On a write/read conflict the side that did not win last conflict goes first.
   assign rd_gnt    = idle && s_arvalid && (!wr_rdy || last_grant_q == GRANT_WRITE);
   assign wr_gnt    = idle && wr_rdy && !rd_gnt;
   assign wr_dec    = addr_decode(64'(aw_addr_q), NAT_ADDR_W);
   assign rd_dec    = addr_decode(64'(s_araddr), NAT_ADDR_W);
   // Partial strobes cannot be expressed on the native port, so they are rejected.
   assign wr_ok     = !wr_dec.err && (&w_strb_q);
   assign s_awready = idle && !aw_held_q;
   assign s_wready  = idle && !w_held_q;
   assign s_arready = rd_gnt;
   assign s_bvalid  = state_q == WR_RESP;
   assign s_rvalid  = state_q == RD_RESP;
   assign s_bresp   = bresp_q;
   assign s_rresp   = rresp_q;
   assign s_rdata   = rdata_q;
   assign nat_en    = nat_en_q;
   assign nat_we    = nat_we_q;
   assign nat_addr  = nat_addr_q;
   assign nat_wdata = nat_wdata_q;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      aw_held_d    = aw_held_q;
      w_held_d     = w_held_q;
      aw_addr_d    = aw_addr_q;
      w_data_d     = w_data_q;
      w_strb_d     = w_strb_q;
      nat_en_d     = 1'b0;
      nat_we_d     = 1'b0;
      nat_addr_d   = nat_addr_q;
      nat_wdata_d  = nat_wdata_q;
      bresp_d      = bresp_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: begin
            if (s_awvalid && s_awready) begin
               aw_held_d = 1'b1;
               aw_addr_d = s_awaddr;
            end
            if (s_wvalid && s_wready) begin
               w_held_d = 1'b1;
               w_data_d = s_wdata;
               w_strb_d = s_wstrb;
            end
            if (idle && wr_rdy && s_arvalid) last_grant_d = rd_gnt ? GRANT_READ : GRANT_WRITE;
            if (wr_gnt) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               nat_en_d  = wr_ok;
               nat_we_d  = wr_ok;
               if (wr_ok) begin
                  nat_addr_d  = NAT_ADDR_W'(wr_dec.word);
                  nat_wdata_d = w_data_q;
               end
               bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
               state_d = WR_RESP;
            end else if (rd_gnt) begin
               cnt_d = 3'd0;
               if (rd_dec.err) begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
                  state_d = RD_RESP;
               end else begin
                  nat_en_d   = 1'b1;
                  nat_addr_d = NAT_ADDR_W'(rd_dec.word);
                  state_d    = RD_WAIT;
               end
            end
         end
         WR_RESP: state_d = s_bready ? IDLE : WR_RESP;
         RD_WAIT: begin
            // cnt_q reaches RD_LATENCY in the cycle nat_rdata is valid.
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(RD_LATENCY)) begin
               rdata_d = nat_rdata;
               rresp_d = RESP_OKAY;
               state_d = RD_RESP;
            end
         end
         RD_RESP: state_d = s_rready ? IDLE : RD_RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_READ;
         aw_held_q    <= 1'b0;
         w_held_q     <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         nat_en_q     <= 1'b0;
         nat_we_q     <= 1'b0;
         nat_addr_q   <= '0;
         nat_wdata_q  <= '0;
         bresp_q      <= RESP_OKAY;
         rresp_q      <= RESP_OKAY;
         rdata_q      <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         aw_held_q    <= aw_held_d;
         w_held_q     <= w_held_d;
         aw_addr_q    <= aw_addr_d;
         w_data_q     <= w_data_d;
         w_strb_q     <= w_strb_d;
         nat_en_q     <= nat_en_d;
         nat_we_q     <= nat_we_d;
         nat_addr_q   <= nat_addr_d;
         nat_wdata_q  <= nat_wdata_d;
         bresp_q      <= bresp_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
      end
   end
endmodule

// File: tb/tb_axil_native_bridge.sv
// tb_axil_native_bridge: directed checks of the AXI4-Lite to native bridge at read latencies 1 and 3.
module tb_axil_native_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr, araddr, araddr3;
   logic        awvalid, wvalid, bready, arvalid, rready, arvalid3, rready3;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [63:0] rdata, nat_wdata, nat_rdata;
   logic        nat_en, nat_we;
   logic [15:0] nat_addr;
   logic        awready3, wready3, bvalid3, arready3, rvalid3, nat_en3, nat_we3;
   logic [1:0]  bresp3, rresp3;
   logic [63:0] rdata3, nat_wdata3, nat_rdata3;
   logic [15:0] nat_addr3;
   logic [63:0] pipe3 [3] = '{64'd0, 64'd0, 64'd0};
   int          errors = 0;
   int          checks = 0;
   int          en_cnt = 0;
   int          e0, bad;

   always #5 clk = ~clk;

   axil_native_bridge #(.RD_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready),
      .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready),
      .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
      .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready),
      .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid), .s_rready(rready),
      .nat_en(nat_en), .nat_we(nat_we), .nat_addr(nat_addr),
      .nat_wdata(nat_wdata), .nat_rdata(nat_rdata)
   );

   axil_native_bridge #(.RD_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .s_awaddr(32'd0), .s_awvalid(1'b0), .s_awready(awready3),
      .s_wdata(64'd0), .s_wstrb(8'd0), .s_wvalid(1'b0), .s_wready(wready3),
      .s_bresp(bresp3), .s_bvalid(bvalid3), .s_bready(1'b0),
      .s_araddr(araddr3), .s_arvalid(arvalid3), .s_arready(arready3),
      .s_rdata(rdata3), .s_rresp(rresp3), .s_rvalid(rvalid3), .s_rready(rready3),
      .nat_en(nat_en3), .nat_we(nat_we3), .nat_addr(nat_addr3),
      .nat_wdata(nat_wdata3), .nat_rdata(nat_rdata3)
   );

   // Native targets: registered read returning the word address (latency 1),
   // and a 3-stage pipe returning word address + 0x100, garbage on non-read cycles.
   always @(posedge clk) begin
      nat_rdata <= (nat_en && !nat_we) ? {48'd0, nat_addr} : 64'hBAD0;
      pipe3[0]  <= (nat_en3 && !nat_we3) ? {48'd0, nat_addr3} + 64'h100 : 64'hBAD3;
      pipe3[1]  <= pipe3[0];
      pipe3[2]  <= pipe3[1];
      if (nat_en) en_cnt <= en_cnt + 1;
   end
   assign nat_rdata3 = pipe3[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_rvalid(input int max);
      int n = 0;
      while (!rvalid && n < max) begin
         step();
         n++;
      end
      check("rvalid_timeout", {63'd0, rvalid}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      {awvalid, wvalid, bready, arvalid, rready, arvalid3, rready3} = '0;
      awaddr = '0; araddr = '0; araddr3 = '0; wdata = '0; wstrb = '0;
      step(); step();
      check("rst_ready", {awready, wready, arready}, 3'b000);
      check("rst_valid", {bvalid, rvalid, nat_en, nat_we}, 4'b0000);
      check("rst_rdata", rdata, 64'd0);
      check("rst_nat", {nat_addr, bresp, rresp}, 20'd0);
      check("rst_wdata", nat_wdata, 64'd0);
      rst = 1'b0;
      step();
      check("idle_ready", {awready, wready, arready}, 3'b110);

      // write with AW and W in the same cycle
      e0 = en_cnt;
      awaddr = 32'h0; wdata = 64'h1; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_decide", {nat_en, awready, wready}, 3'b000);
      step();
      check("wr_issue", {nat_en, nat_we, bvalid}, 3'b111);
      check("wr_addr", nat_addr, 64'd0);
      check("wr_data", nat_wdata, 64'd1);
      check("wr_bresp", bresp, 64'd0);
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("wr_done", {nat_en, bvalid}, 2'b00);
      check("wr_pulses", en_cnt - e0, 64'd1);

      // read, latency 1
      araddr = 32'h8; arvalid = 1'b1;
      #1 check("rd_arready", arready, 64'd1);
      step();
      arvalid = 1'b0;
      check("rd_issue", {nat_en, nat_we, rvalid}, 3'b100);
      check("rd_addr", nat_addr, 64'd1);
      step();
      check("rd_wait", {nat_en, rvalid}, 2'b00);
      step();
      check("rd_rvalid", rvalid, 64'd1);
      check("rd_rdata", rdata, 64'd1);
      check("rd_rresp", rresp, 64'd0);
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("rd_done", rvalid, 64'd0);

      // read, latency 3
      araddr3 = 32'h8; arvalid3 = 1'b1;
      step();
      arvalid3 = 1'b0;
      check("rd3_issue", {nat_en3, nat_we3, nat_addr3}, {1'b1, 1'b0, 16'd1});
      for (int i = 0; i < 3; i++) begin
         step();
         check("rd3_wait", rvalid3, 64'd0);
      end
      step();
      check("rd3_rvalid", rvalid3, 64'd1);
      check("rd3_rdata", rdata3, 64'h101);
      check("rd3_rresp", rresp3, 64'd0);
      rready3 = 1'b1;
      step();
      rready3 = 1'b0;

      // W three cycles ahead of AW
      e0 = en_cnt;
      wdata = 64'h2; wstrb = 8'hFF; wvalid = 1'b1;
      #1 check("ord_wready", wready, 64'd1);
      step();
      wvalid = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (nat_en || wready) bad++;
         step();
      end
      check("ord_hold", bad, 64'd0);
      awaddr = 32'h10; awvalid = 1'b1;
      #1 check("ord_awready", awready, 64'd1);
      step();
      awvalid = 1'b0;
      check("ord_decide", nat_en, 64'd0);
      step();
      check("ord_issue", {nat_en, nat_we, nat_addr}, {1'b1, 1'b1, 16'd2});
      check("ord_data", nat_wdata, 64'd2);
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("ord_pulses", en_cnt - e0, 64'd1);

      // arbitration: first conflict after reset goes to the write
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      awaddr = 32'h18; wdata = 64'h3; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 32'h20; arvalid = 1'b1;
      #1 check("arb1_ar_blocked", arready, 64'd0);
      step();
      check("arb1_write", {nat_en, nat_we, nat_addr}, {1'b1, 1'b1, 16'd3});
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("arb1_ar_now", arready, 64'd1);
      step();
      arvalid = 1'b0;
      check("arb1_read", {nat_en, nat_we, nat_addr}, {1'b1, 1'b0, 16'd4});
      wait_rvalid(6);
      check("arb1_rdata", rdata, 64'd4);
      rready = 1'b1;
      step();
      rready = 1'b0;
      // second conflict goes to the read
      awaddr = 32'h28; wdata = 64'h5; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 32'h30; arvalid = 1'b1;
      #1 check("arb2_ar_first", arready, 64'd1);
      step();
      arvalid = 1'b0;
      check("arb2_read", {nat_en, nat_we, nat_addr}, {1'b1, 1'b0, 16'd6});
      wait_rvalid(6);
      check("arb2_rdata", rdata, 64'd6);
      rready = 1'b1;
      step();
      rready = 1'b0;
      step();
      check("arb2_write", {nat_en, nat_we, nat_addr}, {1'b1, 1'b1, 16'd5});
      check("arb2_wdata", nat_wdata, 64'd5);
      bready = 1'b1;
      step();
      bready = 1'b0;

      // error responses
      e0 = en_cnt;
      awaddr = 32'h4; wdata = 64'h7; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      step();
      check("err_aw", {bvalid, bresp, nat_en}, {1'b1, 2'b10, 1'b0});
      bready = 1'b1;
      step();
      bready = 1'b0;
      araddr = 32'h80000; arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      check("err_ar", {rvalid, rresp, nat_en}, {1'b1, 2'b10, 1'b0});
      check("err_ar_rdata", rdata, 64'd0);
      rready = 1'b1;
      step();
      rready = 1'b0;
      awaddr = 32'h38; wdata = 64'h9; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      step();
      check("err_strb", {bvalid, bresp, nat_en}, {1'b1, 2'b10, 1'b0});
      // B backpressure with a competing AR
      araddr = 32'h8; arvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold", {bvalid, bresp, awready, wready, arready}, {1'b1, 2'b10, 3'b000});
      end
      arvalid = 1'b0; bready = 1'b1;
      step();
      bready = 1'b0;
      check("err_pulses", en_cnt - e0, 64'd0);

      // reset while waiting for read data
      araddr = 32'h8; arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      check("rstrd_issue", nat_en, 64'd1);
      rst = 1'b1;
      #1;
      check("rstrd_ready", {awready, wready, arready}, 3'b000);
      check("rstrd_out", {nat_en, nat_we, rvalid, bvalid, nat_addr}, 20'd0);
      check("rstrd_wdata", nat_wdata, 64'd0);
      check("rstrd_rdata", rdata, 64'd0);
      step();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (rvalid || nat_en) bad++;
      end
      check("rstrd_no_resp", bad, 64'd0);
      check("rstrd_idle", {awready, wready}, 2'b11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
